// File: rtl/vending_controller.sv
// -----------------------------------------------------------------------------
// vending_controller
//
// Transaction sequencer for the vending machine coin/balance datapath.
//   * Tracks the phase: IDLE -> INSERT -> DISPENSE / RETURN.
//   * Reports which items the current balance can buy.
//   * Issues one-cycle debit commands for each dispensed item and each change
//     coin. The datapath owns the balance (coin_total) and the inactivity timer
//     (wait_time).
//   * Pays change out as one coin per cycle, largest coin first.
//
// Optional feature macro: VM_TIMEOUT_RETURN_EN
//   Defined     - when the inactivity timer reaches zero in INSERT with a
//                 non-zero balance, change is returned automatically.
//   Not defined - wait_time is ignored. INSERT waits for a selection or a
//                 return request.
// -----------------------------------------------------------------------------
module vending_controller #(
   parameter int unsigned PRICE0 = 400,
   parameter int unsigned PRICE1 = 500,
   parameter int unsigned PRICE2 = 1000,
   parameter int unsigned PRICE3 = 2000,
   parameter int unsigned COIN0  = 100,
   parameter int unsigned COIN1  = 500,
   parameter int unsigned COIN2  = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  i_input_coin,
   input  logic [3:0]  i_select_item,
   input  logic        i_trigger_return,
   input  logic [31:0] coin_total,
   input  logic [31:0] wait_time,
   output logic [1:0]  o_current_state,
   output logic [3:0]  o_available_item,
   output logic        o_accept_coin,
   output logic [3:0]  o_output_item,
   output logic [2:0]  o_return_coin,
   output logic        o_debit_valid,
   output logic [31:0] o_debit
);

   // The state encoding is also the externally visible o_current_state code.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_INSERT   = 2'b01,
      ST_DISPENSE = 2'b10,
      ST_RETURN   = 2'b11
   } state_t;

   localparam logic [31:0] PRICE0_W = 32'(PRICE0);
   localparam logic [31:0] PRICE1_W = 32'(PRICE1);
   localparam logic [31:0] PRICE2_W = 32'(PRICE2);
   localparam logic [31:0] PRICE3_W = 32'(PRICE3);
   localparam logic [31:0] COIN0_W  = 32'(COIN0);
   localparam logic [31:0] COIN1_W  = 32'(COIN1);
   localparam logic [31:0] COIN2_W  = 32'(COIN2);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t      state_q,     state_d;
   logic [31:0] remaining_q, remaining_d;   // balance still to be paid back
   logic [1:0]  item_q,      item_d;        // index of the item being dispensed

   // ---------------------------------------------------------------------------
   // Helper signals
   // ---------------------------------------------------------------------------
   logic [3:0]  afford;         // raw affordability from the current balance
   logic [3:0]  sel_hit;        // requested and affordable items
   logic [1:0]  sel_idx;        // lowest-index affordable request
   logic [31:0] item_price;     // price of the latched item
   logic [2:0]  chg_coin;       // one-hot change coin chosen this cycle
   logic [31:0] chg_value;      // value of chg_coin
   logic [31:0] remaining_left; // remaining after paying chg_coin
   logic        timeout;        // inactivity return request

   // Unsigned 32-bit affordability compare against each price.
   always_comb begin
      afford[0] = (coin_total >= PRICE0_W);
      afford[1] = (coin_total >= PRICE1_W);
      afford[2] = (coin_total >= PRICE2_W);
      afford[3] = (coin_total >= PRICE3_W);
   end

   assign sel_hit = i_select_item & afford;

   // Lowest set bit of sel_hit wins when several items are requested together.
   always_comb begin
      // NOTE: every always_comb output gets a default first so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      sel_idx = 2'd0;
      if (sel_hit[0]) begin
         sel_idx = 2'd0;
      end else if (sel_hit[1]) begin
         sel_idx = 2'd1;
      end else if (sel_hit[2]) begin
         sel_idx = 2'd2;
      end else if (sel_hit[3]) begin
         sel_idx = 2'd3;
      end
   end

   // Price lookup for the item latched at selection time.
   always_comb begin
      unique case (item_q)
         2'd0:    item_price = PRICE0_W;
         2'd1:    item_price = PRICE1_W;
         2'd2:    item_price = PRICE2_W;
         default: item_price = PRICE3_W;
      endcase
   end

   // Greedy change selection: the largest coin that still fits in remaining.
   always_comb begin
      chg_coin  = 3'b000;
      chg_value = '0;
      if (remaining_q >= COIN2_W) begin
         chg_coin  = 3'b100;
         chg_value = COIN2_W;
      end else if (remaining_q >= COIN1_W) begin
         chg_coin  = 3'b010;
         chg_value = COIN1_W;
      end else if (remaining_q >= COIN0_W) begin
         chg_coin  = 3'b001;
         chg_value = COIN0_W;
      end
   end

   assign remaining_left = remaining_q - chg_value;

`ifdef VM_TIMEOUT_RETURN_EN
   // An expired timer only forces a return when there is money to give back.
   assign timeout = (wait_time == '0) && (coin_total != '0);
`else
   // The timer is not used in this build. The reduction keeps the port
   // visibly consumed.
   logic unused_wait_time;
   assign unused_wait_time = ^wait_time;
   assign timeout          = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   // Next-state, register updates and command outputs for each phase.
   always_comb begin
      state_d          = state_q;
      remaining_d      = remaining_q;
      item_d           = item_q;
      o_available_item = afford;
      o_accept_coin    = 1'b1;
      o_output_item    = 4'b0000;
      o_return_coin    = 3'b000;
      o_debit_valid    = 1'b0;
      o_debit          = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (|i_input_coin) begin
               state_d = ST_INSERT;
            end
         end

         ST_INSERT: begin
            // Selection beats a return request in the same cycle. The
            // affordability check uses the balance before any coin that
            // arrives in the same cycle.
            if (|sel_hit) begin
               item_d  = sel_idx;
               state_d = ST_DISPENSE;
            end else if (i_trigger_return || timeout) begin
               remaining_d = coin_total;
               state_d     = ST_RETURN;
            end
         end

         ST_DISPENSE: begin
            o_available_item = 4'b0000;
            o_output_item    = 4'b0001 << item_q;
            o_debit_valid    = 1'b1;
            o_debit          = item_price;
            state_d          = ST_INSERT;
         end

         ST_RETURN: begin
            o_available_item = 4'b0000;
            o_accept_coin    = 1'b0;
            o_return_coin    = chg_coin;
            o_debit_valid    = |chg_coin;
            o_debit          = chg_value;
            remaining_d      = remaining_left;
            // Leave once less than the smallest coin is left. Any sub-coin
            // residue is dropped.
            if (remaining_left < COIN0_W) begin
               remaining_d = '0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign o_current_state = state_q;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples the values from before the edge, whatever the order
      // of the statements.
      if (reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         item_q      <= 2'd0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         item_q      <= item_d;
      end
   end

endmodule

// File: tb/tb_vending_controller.sv
// -----------------------------------------------------------------------------
// tb_vending_controller
//
// Directed stimulus drives the controller and pushes each expected debit
// command (item pulse, change coin, debit amount) into a scoreboard queue. A
// monitor pops and compares an entry whenever the DUT shows a command. Phase
// and affordability are checked inline against hand-computed constants.
// Honours VM_TIMEOUT_RETURN_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_vending_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  i_input_coin;
   logic [3:0]  i_select_item;
   logic        i_trigger_return;
   logic [31:0] coin_total;
   logic [31:0] wait_time;
   logic [1:0]  o_current_state;
   logic [3:0]  o_available_item;
   logic        o_accept_coin;
   logic [3:0]  o_output_item;
   logic [2:0]  o_return_coin;
   logic        o_debit_valid;
   logic [31:0] o_debit;

   typedef struct packed {
      logic [3:0]  item;
      logic [2:0]  coin;
      logic [31:0] debit;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   vending_controller dut (
      .clk              (clk),
      .reset            (reset),
      .i_input_coin     (i_input_coin),
      .i_select_item    (i_select_item),
      .i_trigger_return (i_trigger_return),
      .coin_total       (coin_total),
      .wait_time        (wait_time),
      .o_current_state  (o_current_state),
      .o_available_item (o_available_item),
      .o_accept_coin    (o_accept_coin),
      .o_output_item    (o_output_item),
      .o_return_coin    (o_return_coin),
      .o_debit_valid    (o_debit_valid),
      .o_debit          (o_debit)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic push(input logic [3:0] item, input logic [2:0] coin, input logic [31:0] debit);
      exp_t e;
      e.item  = item;
      e.coin  = coin;
      e.debit = debit;
      sb.push_back(e);
   endtask

   // Inputs change 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_insert();
      i_input_coin = 3'b001;
      tick();
      i_input_coin = 3'b000;
      check("enter_insert", 32'(o_current_state), 32'd1);
   endtask

   // Monitor: on the falling edge, any command the DUT presents must match
   // the next scoreboard entry.
   always @(negedge clk) begin
      if (o_debit_valid || (|o_output_item) || (|o_return_coin)) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_cmd: item=%b coin=%b debit=%0d valid=%b, expected no command at %0t",
                     o_output_item, o_return_coin, o_debit, o_debit_valid, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_item",  32'(o_output_item), 32'(e.item));
            check("sb_coin",  32'(o_return_coin), 32'(e.coin));
            check("sb_debit", o_debit,            e.debit);
            check("sb_valid", 32'(o_debit_valid), 32'd1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset            = 1'b1;
      i_input_coin     = 3'b000;
      i_select_item    = 4'b0000;
      i_trigger_return = 1'b0;
      coin_total       = 32'd0;
      wait_time        = 32'd5;
      tick();
      tick();
      reset = 1'b0;

      // Reset state.
      check("rst_state",  32'(o_current_state),  32'd0);
      check("rst_accept", 32'(o_accept_coin),    32'd1);
      check("rst_avail",  32'(o_available_item), 32'd0);
      check("rst_coin",   32'(o_return_coin),    32'd0);
      check("rst_valid",  32'(o_debit_valid),    32'd0);

      // Insert 1000: IDLE -> INSERT, affordability and its boundaries.
      i_input_coin = 3'b100;
      tick();
      i_input_coin = 3'b000;
      coin_total   = 32'd1000;
      #1;
      check("insert_state", 32'(o_current_state),  32'd1);
      check("avail_1000",   32'(o_available_item), 32'b0111);
      coin_total = 32'd399;
      #1 check("avail_399",  32'(o_available_item), 32'b0000);
      coin_total = 32'd400;
      #1 check("avail_400",  32'(o_available_item), 32'b0001);
      coin_total = 32'd2000;
      #1 check("avail_2000", 32'(o_available_item), 32'b1111);
      coin_total = 32'd1000;

      // Select item 2 with 1000: one DISPENSE cycle, then back to INSERT.
      i_select_item = 4'b0100;
      push(4'b0100, 3'b000, 32'd1000);
      tick();
      i_select_item = 4'b0000;
      check("disp_state",  32'(o_current_state),  32'd2);
      check("disp_avail",  32'(o_available_item), 32'd0);
      check("disp_accept", 32'(o_accept_coin),    32'd1);
      tick();
      coin_total = 32'd0;
      check("disp_back", 32'(o_current_state), 32'd1);

      // Return 1600: coins 1000, 500, 100 on three cycles, then IDLE.
      coin_total       = 32'd1600;
      i_trigger_return = 1'b1;
      push(4'b0000, 3'b100, 32'd1000);
      push(4'b0000, 3'b010, 32'd500);
      push(4'b0000, 3'b001, 32'd100);
      tick();
      i_trigger_return = 1'b0;
      i_input_coin     = 3'b001;   // ignored while returning
      check("ret_state",  32'(o_current_state),  32'd3);
      check("ret_accept", 32'(o_accept_coin),    32'd0);
      check("ret_avail",  32'(o_available_item), 32'd0);
      tick();
      i_input_coin = 3'b000;
      coin_total   = 32'd600;
      tick();
      coin_total = 32'd100;
      check("ret_state3", 32'(o_current_state), 32'd3);
      tick();
      coin_total = 32'd0;
      check("ret_idle", 32'(o_current_state), 32'd0);

      // Multi-hot select 1001 together with return: item 0 wins, no return.
      go_insert();
      coin_total       = 32'd2000;
      i_select_item    = 4'b1001;
      i_trigger_return = 1'b1;
      push(4'b0001, 3'b000, 32'd400);
      tick();
      i_select_item    = 4'b0000;
      i_trigger_return = 1'b0;
      check("prio_state", 32'(o_current_state), 32'd2);
      tick();
      coin_total = 32'd1600;
      check("prio_back", 32'(o_current_state), 32'd1);

      // An unaffordable selection is ignored.
      coin_total    = 32'd450;
      i_select_item = 4'b0010;
      tick();
      i_select_item = 4'b0000;
      check("unaff_state", 32'(o_current_state), 32'd1);

      // Inactivity timeout with 500 in INSERT.
      coin_total = 32'd500;
      wait_time  = 32'd0;
`ifdef VM_TIMEOUT_RETURN_EN
      push(4'b0000, 3'b010, 32'd500);
      tick();
      check("tmo_state", 32'(o_current_state), 32'd3);
      tick();
      check("tmo_idle", 32'(o_current_state), 32'd0);
      wait_time  = 32'd5;
      coin_total = 32'd0;
      go_insert();
`else
      tick();
      check("tmo_ignored1", 32'(o_current_state), 32'd1);
      tick();
      check("tmo_ignored2", 32'(o_current_state), 32'd1);
      wait_time = 32'd5;
`endif

      // Residue below the smallest coin: one RETURN cycle with no coin.
      coin_total       = 32'd50;
      i_trigger_return = 1'b1;
      tick();
      i_trigger_return = 1'b0;
      check("res_state", 32'(o_current_state), 32'd3);
      check("res_coin",  32'(o_return_coin),   32'd0);
      check("res_valid", 32'(o_debit_valid),   32'd0);
      tick();
      check("res_idle", 32'(o_current_state), 32'd0);

      // Reset during the second RETURN cycle of a 1600 return.
      coin_total = 32'd0;
      go_insert();
      coin_total       = 32'd1600;
      i_trigger_return = 1'b1;
      push(4'b0000, 3'b100, 32'd1000);
      push(4'b0000, 3'b010, 32'd500);
      tick();
      i_trigger_return = 1'b0;
      tick();
      coin_total = 32'd600;
      reset      = 1'b1;
      tick();
      check("mrst_state",  32'(o_current_state), 32'd0);
      check("mrst_coin",   32'(o_return_coin),   32'd0);
      check("mrst_valid",  32'(o_debit_valid),   32'd0);
      check("mrst_accept", 32'(o_accept_coin),   32'd1);
      reset = 1'b0;
      repeat (4) tick();
      check("mrst_quiet_state", 32'(o_current_state), 32'd0);
      check("mrst_quiet_coin",  32'(o_return_coin),   32'd0);

      // Every expected command must have been observed.
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/vending_controller.md
# vending_controller

Sequencing FSM for the vending machine coin/balance datapath. It tracks the transaction phase and tells the datapath which items can be bought. It issues one-cycle debit commands for dispensing and change return, and breaks the returned balance into one coin per cycle. It sits between the top-level user inputs and the balance/wait-timer datapath, which owns `coin_total` and `wait_time`.

## Interface
Parameters:
- `PRICE0`, default 400: item 0 price
- `PRICE1`, default 500: item 1 price
- `PRICE2`, default 1000: item 2 price
- `PRICE3`, default 2000: item 3 price
- `COIN0` / `COIN1` / `COIN2`, defaults 100 / 500 / 1000: coin values, one-hot bit 0/1/2

Ports:
- `clk`, in, 1: single clock, all logic on posedge
- `reset`, in, 1: synchronous, active-high
- `i_input_coin`, in, 3: coin insertion, one-hot
- `i_select_item`, in, 4: item request, one-hot or multi-hot
- `i_trigger_return`, in, 1: user return request
- `coin_total`, in, 32: current balance from datapath
- `wait_time`, in, 32: inactivity countdown from datapath
- `o_current_state`, out, 2: 00 IDLE, 01 INSERT, 10 DISPENSE, 11 RETURN
- `o_available_item`, out, 4: bit i = item i affordable
- `o_accept_coin`, out, 1: datapath may add inserted coins
- `o_output_item`, out, 4: one-hot dispense pulse
- `o_return_coin`, out, 3: one-hot change coin this cycle
- `o_debit_valid`, out, 1: datapath must subtract `o_debit` this cycle
- `o_debit`, out, 32: amount to subtract

## Operation
- Reset values: state IDLE; remaining register 0; latched item 0; all outputs 0 except `o_accept_coin`=1.
- `o_available_item[i]` = (`coin_total` >= PRICEi), forced to 0 in DISPENSE and RETURN. The compare is unsigned, 32-bit.
- `o_accept_coin` = 0 in RETURN only. Coins arriving in RETURN are ignored.
- IDLE: any `i_input_coin` bit set -> INSERT.
- INSERT:
  - Compute `(i_select_item & o_available_item) != 0`. If true, latch the lowest-index set bit -> DISPENSE.
  - Else if `i_trigger_return` -> RETURN.
  - Else if timeout (see Configuration) -> RETURN.
  - Else stay in INSERT.
  - A selection of an unaffordable item is ignored.
  - Selection has priority over return when both occur in the same cycle.
  - A coin arriving in the same cycle as a selection is still accepted. Affordability uses the pre-coin `coin_total`.
- DISPENSE, exactly 1 cycle:
  - `o_output_item` = latched item.
  - `o_debit_valid`=1, `o_debit`=price of the item.
  - -> INSERT.
- RETURN:
  - On the entry edge, load remaining <= `coin_total`.
  - Each cycle, pick the largest coin <= remaining: 1000, else 500, else 100, else none.
  - Drive `o_return_coin` one-hot with that coin. Drive `o_debit`=its value with `o_debit_valid`=1.
  - Update remaining <= remaining − value.
  - Transition to IDLE on the edge where the post-subtraction remaining is < 100.
  - A residue < 100 is dropped; remaining is cleared to 0 on exit.
  - On entry with remaining < 100, the block spends 1 cycle in RETURN with no coin, then goes to IDLE.
- `o_output_item`, `o_return_coin` and `o_debit*` are 0 whenever they are not being driven as above.

## Timing
- Selection sampled at edge N -> `o_output_item`/debit valid in cycle N..N+1, state DISPENSE. Back in INSERT after edge N+1.
- `o_return_coin` holds at most one coin per cycle. A change return of k coins occupies exactly k RETURN cycles (minimum 1).
- `o_available_item` is combinational from `coin_total` and state. It reflects a datapath debit one cycle after `o_debit_valid`.
- Reset asserted mid-DISPENSE or mid-RETURN: the next edge forces IDLE with all outputs at reset values. No partial coin or item pulse follows.

## Configuration
- `VM_TIMEOUT_RETURN_EN` defined: in INSERT, `wait_time`==0 with `coin_total` > 0 is a timeout, and the FSM enters RETURN. It has the lowest priority, below selection and `i_trigger_return`.
- Not defined: `wait_time` is ignored. INSERT persists until a selection or `i_trigger_return`.

## Test plan
- Reset, then insert 1000 (`i_input_coin`=100), `coin_total`=1000 -> state 01, `o_available_item`=0111.
- `coin_total`=1000, select 0100 -> one cycle of `o_output_item`=0100, `o_debit`=1000, state 10 then 01.
- `coin_total`=1600, `i_trigger_return` -> `o_return_coin` 100, 010, 001 on 3 consecutive cycles. `o_debit` is 1000, 500, 100. Then state 00.
- `coin_total`=2000, select 1001 together with `i_trigger_return` -> item 0001 dispensed (`o_debit`=400), no return.
- Macro defined: `coin_total`=500, `wait_time`=0 in INSERT -> RETURN, one coin 010, then IDLE. Macro undefined: state stays 01.
- Reset asserted in the 2nd RETURN cycle of a 1600 return -> next cycle state 00, `o_return_coin`=000, no further coins.
